output_holder: RTL
==================

OUTPUT_HOLDER -- requirements
Module: output_holder

Interface
REQ-001 Parameter DATA_W, default 8, width of one cipher result word.
REQ-002 Parameter DEPTH, default 4, number of buffered result words; a power of two and at least 2.
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 nrst  input  1  reset, asynchronous and active-low.
REQ-005 result_data  input  DATA_W  cipher core result word.
REQ-006 result_valid  input  1  result_data valid this cycle; one word per cycle.
REQ-007 result_ready  output  1  buffer can accept a word this cycle.
REQ-008 output_acknowledge  input  1  chip pin; host has taken output_data.
REQ-009 output_data  output  DATA_W  word presented on chip pins.
REQ-010 output_is_ready  output  1  output_data valid; also feeds the interface FSM.
REQ-011 overflow  output  1  sticky flag; a word was dropped.

Function
REQ-012 Buffer SHALL be a DEPTH-entry FIFO with read/write pointers that wrap modulo DEPTH and an occupancy count of width clog2(DEPTH)+1.
REQ-013 result_ready SHALL equal "count < DEPTH", computed from registered count only; a pop in the same cycle does not raise it.
REQ-014 A push SHALL occur at the rising edge where result_valid and result_ready are both 1.
REQ-015 result_valid while result_ready is 0 SHALL drop the word, leave the FIFO unchanged and set overflow at that edge.
REQ-016 Presentation FSM states SHALL be EMPTY, PRESENT and WAIT_ACK_LOW.
REQ-017 EMPTY -> PRESENT SHALL occur at the edge where registered count is nonzero, so output_is_ready rises one cycle after the pushing edge.
REQ-018 In PRESENT, output_is_ready SHALL be 1 and output_data SHALL equal the FIFO head, stable until the pop.
REQ-019 In PRESENT with effective acknowledge 1, the FSM SHALL pop the head and go to WAIT_ACK_LOW at the same edge.
REQ-020 In WAIT_ACK_LOW, output_is_ready SHALL be 0; when effective acknowledge is 0, go to PRESENT if count > 0, else to EMPTY.
REQ-021 One acknowledge pulse of any length SHALL pop exactly one word (4-phase handshake).
REQ-022 Acknowledge in EMPTY SHALL be ignored; acknowledge still high on entry to PRESENT SHALL pop at once (host protocol violation, no error flag).
REQ-023 A simultaneous push and pop SHALL leave count unchanged and write the new word at the tail.
REQ-024 output_data SHALL be 0 whenever output_is_ready is 0.

Reset
REQ-025 While nrst is 0: FSM in EMPTY, pointers and count 0, overflow 0, output_is_ready 0, output_data 0, result_ready 1, synchronizer flops 0.
REQ-026 Reset asserted mid-handshake or mid-push SHALL discard all buffered words at once; after release, no output until a new push.

Configuration
REQ-027 Macro OUTPUT_HOLDER_ACK_SYNC_EN: when defined, output_acknowledge SHALL pass through a two-flop synchronizer; effective acknowledge lags the pin by 2 cycles.
REQ-028 When the macro is undefined, effective acknowledge SHALL be output_acknowledge used directly, with zero added latency.

Verification
REQ-029 Reset, push 0xA5 at edge N -> output_is_ready=1 and output_data=0xA5 from edge N+1; ack high 3 cycles, then low -> exactly one pop; output_is_ready=0 during WAIT_ACK_LOW; FSM back in EMPTY.
REQ-030 Push 0x11, 0x22, 0x33, 0x44 back-to-back with ack held 0 -> result_ready=0 after the fourth push; push 0x55 -> overflow=1, 0x55 dropped; four handshakes return 0x11, 0x22, 0x33, 0x44 in order.
REQ-031 FIFO full, push and ack-pop in the same cycle -> push refused (result_ready was 0), overflow=1; one cycle later, with count 3, result_ready=1.
REQ-032 Count 2, push during the pop edge -> count stays 2; tail holds the new word; order preserved across pointer wrap after 6 total pushes.
REQ-033 nrst pulsed low while in PRESENT with 3 words buffered -> output_is_ready=0, output_data=0 and overflow=0 during reset; no presentation after release until a new push.
REQ-034 With OUTPUT_HOLDER_ACK_SYNC_EN defined -> ack rise to output_is_ready fall is 3 cycles; undefined -> 1 cycle.

Source files
------------

// File: rtl/output_holder.sv
// Result buffer between the cipher core and the chip output pins: DEPTH-word FIFO plus a
// 4-phase acknowledge presentation FSM. Define OUTPUT_HOLDER_ACK_SYNC_EN to synchronize the ack pin.
module output_holder #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [DATA_W-1:0] result_data,
  input  logic              result_valid,
  output logic              result_ready,
  input  logic              output_acknowledge,
  output logic [DATA_W-1:0] output_data,
  output logic              output_is_ready,
  output logic              overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    EMPTY,
    PRESENT,
    WAIT_ACK_LOW
  } state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic              ack_eff;
  logic              push, pop;

`ifdef OUTPUT_HOLDER_ACK_SYNC_EN
  logic ack_s1, ack_s2;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ack_s1 <= 1'b0;
      ack_s2 <= 1'b0;
    end else begin
      ack_s1 <= output_acknowledge;
      ack_s2 <= ack_s1;
    end
  end

  always_comb ack_eff = ack_s2;
`else
  always_comb ack_eff = output_acknowledge;
`endif

  // Ready comes from the registered count only; a same-cycle pop cannot make room.
  always_comb result_ready = (count < CW'(DEPTH));
  always_comb push         = result_valid && result_ready;
  always_comb pop          = (state == PRESENT) && ack_eff;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= result_data;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (result_valid && !result_ready) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= EMPTY;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:        if (count != '0) state_nxt = PRESENT;
      PRESENT:      if (ack_eff) state_nxt = WAIT_ACK_LOW;
      WAIT_ACK_LOW: if (!ack_eff) state_nxt = (count != '0) ? PRESENT : EMPTY;
      default:      state_nxt = EMPTY;
    endcase
  end

  always_comb begin
    output_is_ready = (state == PRESENT);
    output_data     = output_is_ready ? mem[rd_ptr] : '0;
  end

endmodule
